seq_detect_multi: RTL and testbench
===================================

Name: seq_detect_multi

Overview:
- Parametrised serial bit-sequence detector. Successor to the team's fixed 11/101/1011 Moore detector.
- Matches up to NUM_PAT runtime-programmable patterns, each 1..MAX_LEN bits, on a qualified serial input.
- Overlapping or non-overlapping detection is selectable. Outputs are registered (Moore style): per-pattern match flags, a combined flag, a priority index and a saturating match counter.
- Sits after the serial receive front-end; feeds event logic and status registers.

Parameters:
NUM_PAT, 3, number of pattern slots (>=1)
MAX_LEN, 8, max pattern length in bits (>=4)
CNT_W, 16, match counter width
(derived) LEN_W = clog2(MAX_LEN+1); IDX_W = max(1, clog2(NUM_PAT))

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in  in  1  serial data bit
in_valid  in  1  qualifies in; a bit is accepted on an edge where in_valid=1
overlap  in  1  1 = overlapping detection, 0 = non-overlapping
clr  in  1  sync flush of history and counter; patterns kept
cfg_we  in  1  pattern slot write strobe
cfg_idx  in  IDX_W  slot to write
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] = first received, bit [0] = last received
cfg_len  in  LEN_W  pattern length; 0 = slot disabled
match  out  NUM_PAT  per-slot match flags
z  out  1  OR of match
match_id  out  IDX_W  lowest matching slot index; 0 when z=0
match_count  out  CNT_W  count of accepted bits with z=1, saturating

Behaviour:
- State:
  - hist[MAX_LEN-1:0], where hist[0] is the newest bit.
  - hcnt (0..MAX_LEN), the number of valid history bits.
  - Per-slot pat/len registers.
  - Output registers.
- Reset (rst=1 at an edge), and also on reset mid-stream:
  - hist=0, hcnt=0, match=0, z=0, match_id=0, match_count=0.
  - Slot 0 = 2'b11 len 2; slot 1 = 3'b101 len 3; slot 2 = 4'b1011 len 4; slots >=3 len 0.
  - rst has priority over every other input.
- Accepted bit (in_valid=1, no rst, no clr):
  - nh = {hist[MAX_LEN-2:0], in}; nc = min(hcnt+1, MAX_LEN).
  - Slot i hits when len_i != 0, len_i <= MAX_LEN, nc >= len_i and nh[len_i-1:0] == pat_i[len_i-1:0].
  - The hit vector is registered into match at this edge. Latency: the flag is visible the cycle after the edge that accepted the completing bit, for exactly one cycle per accepted bit.
  - hist <= nh.
  - hcnt <= nc if overlap=1 or no slot hit. If overlap=0 and any slot hit, hcnt <= 0, so the next match needs entirely fresh bits.
  - match_count increments when any slot hits; holds at 2^CNT_W-1.
- in_valid=0 edge: hist, hcnt and match_count hold; match, z and match_id go 0.
- clr=1 (no rst): hcnt=0, match_count=0, match/z/match_id=0, hist=0. The in bit that cycle is discarded; cfg_we is still honoured.
- cfg_we=1:
  - Slot cfg_idx takes cfg_pattern/cfg_len at the edge.
  - cfg_idx >= NUM_PAT: write ignored.
  - cfg_len > MAX_LEN: stored, but the slot never hits.
  - A bit accepted on the same edge is compared against the old pattern; the new pattern applies from the next accepted bit.
  - History is not flushed by a write.
- Bits of pat_i above len_i-1 are don't-care.
- match_id is a priority encode of the registered match vector (lowest index wins).
- Outputs are driven only from registers; no combinational path from in to any output.

Test Plan:
1. Reset, overlap=1, defaults, stream 1,1,0,1,0,1,1 (in_valid=1 continuous) -> match per bit 000,001,000,010,000,010,101. On the last bit z=1, match_id=0. Final match_count=4.
2. Same stream with overlap=0 -> match 000,001,000,000,000,010,000; match_count=2.
3. Write slot 0 = 8'b10110011 len 8, overlap=1. Stream 1,0,1,1,0,0,1,1 with in_valid dropped for 2 cycles after bit 4 -> match[0] pulses only after bit 8. match=000 during the gaps; match_count=1.
4. Mid-stream rst after bits 1,0 (pattern 101 pending), then bit 1 -> no match. Slots read back as defaults; match_count=0.
5. CNT_W=4, overlap=1, defaults, stream 20 ones -> match[0]=1 from bit 2 onward. match_count saturates at 15 and holds.
6. Same-edge events: cfg_we writing slot 1 to len 0 on the edge accepting the completing '1' of 101 -> match[1] still fires for that bit, and never again. clr together with in_valid -> bit discarded, match_count=0.

Source files
------------

// File: rtl/seq_detect_multi.sv
// Purpose: serial bit-sequence detector matching up to NUM_PAT programmable patterns, overlapping or not.
// Latency: match/z/match_id/match_count update one cycle after the edge accepting the completing bit.
// Backpressure: none; in_valid=0 pauses history and counter and zeroes the match flags for that cycle.
module seq_detect_multi #(
   parameter int NUM_PAT = 3,
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 16,
   localparam int LEN_W  = $clog2(MAX_LEN + 1),
   localparam int IDX_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in,
   input  logic               in_valid,
   input  logic               overlap,
   input  logic               clr,
   input  logic               cfg_we,
   input  logic [IDX_W-1:0]   cfg_idx,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   output logic [NUM_PAT-1:0] match,
   output logic               z,
   output logic [IDX_W-1:0]   match_id,
   output logic [CNT_W-1:0]   match_count
);

   // Power-on pattern set mirrors the legacy fixed detector: 11, 101, 1011.
   function automatic logic [MAX_LEN-1:0] dflt_pat(input int i);
      case (i)
         0:       dflt_pat = MAX_LEN'(4'b0011);
         1:       dflt_pat = MAX_LEN'(4'b0101);
         2:       dflt_pat = MAX_LEN'(4'b1011);
         default: dflt_pat = '0;
      endcase
   endfunction

   function automatic logic [LEN_W-1:0] dflt_len(input int i);
      case (i)
         0:       dflt_len = LEN_W'(2);
         1:       dflt_len = LEN_W'(3);
         2:       dflt_len = LEN_W'(4);
         default: dflt_len = '0;
      endcase
   endfunction

   // Lowest set index wins; zero when nothing is set.
   function automatic logic [IDX_W-1:0] prio(input logic [NUM_PAT-1:0] v);
      prio = '0;
      for (int i = NUM_PAT - 1; i >= 0; i--) begin
         if (v[i]) prio = IDX_W'(i);
      end
   endfunction

   logic [MAX_LEN-1:0] pat [NUM_PAT];
   logic [LEN_W-1:0]   len [NUM_PAT];
   logic [MAX_LEN-1:0] hist;
   logic [LEN_W-1:0]   hcnt;
   logic [MAX_LEN-1:0] nh;
   logic [LEN_W-1:0]   nc;
   logic [NUM_PAT-1:0] hit;

   // Candidate history and valid-bit count if the current bit is accepted.
   always_comb begin
      nh = {hist[MAX_LEN-2:0], in};
      nc = (hcnt == LEN_W'(MAX_LEN)) ? hcnt : hcnt + 1'b1;
   end

   for (genvar g = 0; g < NUM_PAT; g++) begin : g_slot
      logic [MAX_LEN-1:0] mask;

      // Only the low len bits of a pattern take part in the compare.
      always_comb begin
         mask = '0;
         for (int b = 0; b < MAX_LEN; b++) begin
            mask[b] = (b < int'(len[g]));
         end
      end

      // Oversized lengths are kept in the slot but can never hit.
      assign hit[g] = (len[g] != '0) && (len[g] <= LEN_W'(MAX_LEN)) && (nc >= len[g]) &&
                      (((nh ^ pat[g]) & mask) == '0);
   end

   // Pattern slots: reset restores defaults; writes survive clr and take effect after this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_PAT; i++) begin
            pat[i] <= dflt_pat(i);
            len[i] <= dflt_len(i);
         end
      end else if (cfg_we && (int'(cfg_idx) < NUM_PAT)) begin
         pat[cfg_idx] <= cfg_pattern;
         len[cfg_idx] <= cfg_len;
      end
   end

   // History, match outputs and saturating counter; non-overlap mode restarts history count on a hit.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         hist        <= '0;
         hcnt        <= '0;
         match       <= '0;
         z           <= 1'b0;
         match_id    <= '0;
         match_count <= '0;
      end else if (in_valid) begin
         hist     <= nh;
         hcnt     <= (overlap || (hit == '0)) ? nc : '0;
         match    <= hit;
         z        <= |hit;
         match_id <= prio(hit);
         if ((|hit) && (match_count != {CNT_W{1'b1}})) begin
            match_count <= match_count + 1'b1;
         end
      end else begin
         match    <= '0;
         z        <= 1'b0;
         match_id <= '0;
      end
   end

endmodule

// File: tb/tb_seq_detect_multi.sv
// Purpose: directed self-checking bench for seq_detect_multi (default build plus a CNT_W=4 build).
// Latency: each bit is driven 1 time unit after a rising edge and outputs are checked 1 unit after the next.
// Backpressure: not applicable; the bench drives in_valid gaps directly.
module tb_seq_detect_multi;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in = 1'b0;
   logic       in_valid = 1'b0;
   logic       overlap = 1'b1;
   logic       clr = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_idx = '0;
   logic [7:0] cfg_pattern = '0;
   logic [3:0] cfg_len = '0;

   logic [2:0]  match;
   logic        z;
   logic [1:0]  match_id;
   logic [15:0] match_count;

   logic [2:0]  match4;
   logic        z4;
   logic [1:0]  match_id4;
   logic [3:0]  match_count4;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   seq_detect_multi u_dut (
      .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .overlap(overlap), .clr(clr),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .match(match), .z(z), .match_id(match_id), .match_count(match_count)
   );

   seq_detect_multi #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .overlap(overlap), .clr(clr),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .match(match4), .z(z4), .match_id(match_id4), .match_count(match_count4)
   );

   // One clock with the given bit/valid presented; returns 1 unit after the edge.
   task automatic cyc(input logic b, input logic v);
      in = b;
      in_valid = v;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1'b0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic cfg_write(input logic [1:0] idx, input logic [7:0] p, input logic [3:0] l);
      cfg_we = 1'b1;
      cfg_idx = idx;
      cfg_pattern = p;
      cfg_len = l;
      cyc(1'b0, 1'b0);
      cfg_we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in = 1'b1;
      in_valid = 1'b1;
      clr = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      clr = 1'b0;
      n_chk++;
      if (match !== 3'b000) begin n_fail++; $display("FAIL reset_match got=%b exp=000", match); end
      n_chk++;
      if (z !== 1'b0) begin n_fail++; $display("FAIL reset_z got=%b exp=0", z); end
      n_chk++;
      if (match_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got=%0d exp=0", match_id); end
      n_chk++;
      if (match_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", match_count); end
      n_chk++;
      if (match_count4 !== 4'd0) begin n_fail++; $display("FAIL reset_count4 got=%0d exp=0", match_count4); end
   endtask

   task automatic test_overlap();
      logic [6:0] bits = 7'b1101011;
      logic [2:0] exp [7] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b010, 3'b101};
      logic [1:0] exp_id [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
      do_reset();
      overlap = 1'b1;
      for (int k = 0; k < 7; k++) begin
         cyc(bits[6-k], 1'b1);
         n_chk++;
         if (match !== exp[k] || z !== (|exp[k]) || match_id !== exp_id[k]) begin
            n_fail++;
            $display("FAIL overlap_bit%0d got match=%b z=%b id=%0d exp match=%b z=%b id=%0d",
                     k + 1, match, z, match_id, exp[k], |exp[k], exp_id[k]);
         end
      end
      n_chk++;
      if (match_count !== 16'd4) begin n_fail++; $display("FAIL overlap_count got=%0d exp=4", match_count); end
   endtask

   task automatic test_nonoverlap();
      logic [6:0] bits = 7'b1101011;
      logic [2:0] exp [7] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000};
      do_reset();
      overlap = 1'b0;
      for (int k = 0; k < 7; k++) begin
         cyc(bits[6-k], 1'b1);
         n_chk++;
         if (match !== exp[k]) begin
            n_fail++;
            $display("FAIL nonoverlap_bit%0d got=%b exp=%b", k + 1, match, exp[k]);
         end
      end
      n_chk++;
      if (match_count !== 16'd2) begin n_fail++; $display("FAIL nonoverlap_count got=%0d exp=2", match_count); end
      overlap = 1'b1;
   endtask

   task automatic test_long_pattern();
      logic [7:0] bits = 8'b10110011;
      do_reset();
      overlap = 1'b1;
      cfg_write(2'd1, 8'h00, 4'd0);
      cfg_write(2'd2, 8'h00, 4'd0);
      cfg_write(2'd0, 8'b10110011, 4'd8);
      for (int k = 0; k < 8; k++) begin
         cyc(bits[7-k], 1'b1);
         n_chk++;
         if (match !== ((k == 7) ? 3'b001 : 3'b000)) begin
            n_fail++;
            $display("FAIL long_bit%0d got=%b exp=%b", k + 1, match, (k == 7) ? 3'b001 : 3'b000);
         end
         if (k == 3) begin
            for (int g = 0; g < 2; g++) begin
               cyc(1'b1, 1'b0);
               n_chk++;
               if (match !== 3'b000) begin n_fail++; $display("FAIL long_gap%0d got=%b exp=000", g, match); end
            end
         end
      end
      n_chk++;
      if (match_count !== 16'd1) begin n_fail++; $display("FAIL long_count got=%0d exp=1", match_count); end
   endtask

   task automatic test_mid_reset();
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b1);
      rst = 1'b1;
      cyc(1'b1, 1'b1);
      rst = 1'b0;
      n_chk++;
      if (match !== 3'b000 || match_count !== 16'd0) begin
         n_fail++;
         $display("FAIL midrst_state got match=%b count=%0d exp match=000 count=0", match, match_count);
      end
      cyc(1'b1, 1'b1);
      n_chk++;
      if (match !== 3'b000) begin n_fail++; $display("FAIL midrst_nomatch got=%b exp=000", match); end
      cyc(1'b1, 1'b1);
      n_chk++;
      if (match !== 3'b001) begin n_fail++; $display("FAIL midrst_default_slot0 got=%b exp=001", match); end
      n_chk++;
      if (match_count !== 16'd1) begin n_fail++; $display("FAIL midrst_count got=%0d exp=1", match_count); end
   endtask

   task automatic test_saturate();
      logic [3:0] exp_cnt;
      do_reset();
      overlap = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         cyc(1'b1, 1'b1);
         exp_cnt = (k - 1 > 15) ? 4'd15 : 4'(k - 1);
         n_chk++;
         if (match4 !== ((k >= 2) ? 3'b001 : 3'b000) || match_count4 !== exp_cnt) begin
            n_fail++;
            $display("FAIL sat_bit%0d got match=%b count=%0d exp match=%b count=%0d",
                     k, match4, match_count4, (k >= 2) ? 3'b001 : 3'b000, exp_cnt);
         end
      end
      cyc(1'b1, 1'b0);
      n_chk++;
      if (match_count4 !== 4'd15 || match4 !== 3'b000) begin
         n_fail++;
         $display("FAIL sat_hold got match=%b count=%0d exp match=000 count=15", match4, match_count4);
      end
   endtask

   task automatic test_same_edge();
      do_reset();
      overlap = 1'b1;
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b1);
      cfg_we = 1'b1;
      cfg_idx = 2'd1;
      cfg_pattern = 8'h00;
      cfg_len = 4'd0;
      cyc(1'b1, 1'b1);
      cfg_we = 1'b0;
      n_chk++;
      if (match !== 3'b010) begin n_fail++; $display("FAIL same_edge_old_pat got=%b exp=010", match); end
      cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b1);
      n_chk++;
      if (match !== 3'b000) begin n_fail++; $display("FAIL same_edge_disabled got=%b exp=000", match); end
      n_chk++;
      if (match_count !== 16'd1) begin n_fail++; $display("FAIL same_edge_count got=%0d exp=1", match_count); end
      clr = 1'b1;
      cyc(1'b1, 1'b1);
      clr = 1'b0;
      n_chk++;
      if (match_count !== 16'd0 || match !== 3'b000 || z !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_state got match=%b z=%b count=%0d exp match=000 z=0 count=0", match, z, match_count);
      end
      cyc(1'b1, 1'b1);
      n_chk++;
      if (match !== 3'b000) begin n_fail++; $display("FAIL clr_discard got=%b exp=000", match); end
      cfg_write(2'd0, 8'hFF, 4'd9);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 1'b1);
         n_chk++;
         if (match !== 3'b000) begin n_fail++; $display("FAIL oversize_len_bit%0d got=%b exp=000", k, match); end
      end
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_long_pattern();
      test_mid_reset();
      test_saturate();
      test_same_edge();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
